// File: rtl/fft_transpose_ctrl_pkg.sv
// Shared types and limits for the radix-2 -> radix-3/5 transpose buffer sequencer.
package fft_tr_pkg;

   localparam int MAX_N2  = 256;
   localparam int MAX_N35 = 243;
   localparam int ROW_W   = 8;
   localparam int COL_W   = 8;
   localparam int N2_W    = 9;
   localparam int N35_W   = 8;
   localparam int CNT_W   = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      XFER1 = 2'd2,
      XFER2 = 2'd3
   } state_t;

   // A dimension of zero or beyond the buffer size cannot be sequenced.
   function automatic logic cfg_legal(input logic [N2_W-1:0] n2, input logic [N35_W-1:0] n35);
      return (n2 != '0) && (n2 <= N2_W'(MAX_N2)) && (n35 != '0) && (n35 <= N35_W'(MAX_N35));
   endfunction

endpackage

// File: rtl/fft_transpose_ctrl_if.sv
// Handshake and buffer-address bundle between the transpose sequencer and its environment.
interface fft_transpose_ctrl_if;
   import fft_tr_pkg::*;

   logic             s_valid;
   logic             s_ready;
   logic             eng_valid;
   logic             eng_ready;
   logic             res_valid;
   logic             out_valid;
   logic             out_ready;
   logic             wr_en;
   logic [ROW_W-1:0] wr_row;
   logic [COL_W-1:0] wr_col;
   logic [ROW_W-1:0] rd_row;
   logic [COL_W-1:0] rd_col;

   modport master (
      input  s_valid, eng_ready, res_valid, out_ready,
      output s_ready, eng_valid, out_valid, wr_en, wr_row, wr_col, rd_row, rd_col
   );

   modport slave (
      output s_valid, eng_ready, res_valid, out_ready,
      input  s_ready, eng_valid, out_valid, wr_en, wr_row, wr_col, rd_row, rd_col
   );

endinterface

// File: rtl/fft_transpose_ctrl_rc_counter.sv
// Two-dimensional row/column address counter; row_fast selects which index wraps first.
module rc_counter
   import fft_tr_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             row_fast,
   input  logic [N2_W-1:0]  n_rows,
   input  logic [N35_W-1:0] n_cols,
   output logic [ROW_W-1:0] row,
   output logic [COL_W-1:0] col,
   output logic             last
);

   logic row_end;
   logic col_end;

   assign row_end = ({1'b0, row} == (n_rows - 9'd1));
   assign col_end = (col == (n_cols - 8'd1));
   assign last    = row_end && col_end;

   // Wrapping to zero after the last point leaves the counter ready for the next pass.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row <= '0;
         col <= '0;
      end else if (clr) begin
         row <= '0;
         col <= '0;
      end else if (en) begin
         if (last) begin
            row <= '0;
            col <= '0;
         end else if (row_fast) begin
            if (row_end) begin
               row <= '0;
               col <= col + 8'd1;
            end else begin
               row <= row + 8'd1;
            end
         end else begin
            if (col_end) begin
               col <= '0;
               row <= row + 8'd1;
            end else begin
               col <= col + 8'd1;
            end
         end
      end
   end

endmodule

// File: rtl/fft_transpose_ctrl.sv
// Sequencer for the N2 x N35 transpose buffer: fill column-major, run the radix-3/5
// engine row-major with in-place write-back, then drain column-major downstream.
module fft_transpose_ctrl
   import fft_tr_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [N2_W-1:0]      cfg_n2,
   input  logic [N35_W-1:0]     cfg_n35,
   fft_transpose_ctrl_if.master bus,
   output logic                 busy,
   output logic                 done,
   output logic                 cfg_err,
   output logic                 proto_err
);

   state_t             state;
   logic [N2_W-1:0]    n2_q;
   logic [N35_W-1:0]   n35_q;
   logic [CNT_W-1:0]   pending;
   logic               s_ready_q;
   logic               eng_valid_q;
   logic               out_valid_q;

   logic               go;
   logic               fill_hs;
   logic               issue_hs;
   logic               res_acc;
   logic               out_hs;

   logic [ROW_W-1:0]   fill_row, iss_row, col_row, out_row;
   logic [COL_W-1:0]   fill_col, iss_col, col_col, out_col;
   logic               fill_last, iss_last, col_last, out_last;

   assign go       = (state == IDLE) && start && cfg_legal(cfg_n2, cfg_n35);
   assign fill_hs  = bus.s_valid && s_ready_q;
   assign issue_hs = eng_valid_q && bus.eng_ready;
   // A result is only taken while one is outstanding, so collect can never overtake issue.
   assign res_acc  = (state == XFER1) && bus.res_valid && (pending != '0);
   assign out_hs   = out_valid_q && bus.out_ready;

   assign bus.s_ready   = s_ready_q;
   assign bus.eng_valid = eng_valid_q;
   assign bus.out_valid = out_valid_q;
   assign bus.wr_en     = fill_hs || res_acc;

   rc_counter u_fill (
      .clk(clk), .rst(rst), .en(fill_hs), .clr(go), .row_fast(1'b1),
      .n_rows(n2_q), .n_cols(n35_q), .row(fill_row), .col(fill_col), .last(fill_last)
   );

   rc_counter u_issue (
      .clk(clk), .rst(rst), .en(issue_hs), .clr(go), .row_fast(1'b0),
      .n_rows(n2_q), .n_cols(n35_q), .row(iss_row), .col(iss_col), .last(iss_last)
   );

   rc_counter u_collect (
      .clk(clk), .rst(rst), .en(res_acc), .clr(go), .row_fast(1'b0),
      .n_rows(n2_q), .n_cols(n35_q), .row(col_row), .col(col_col), .last(col_last)
   );

   rc_counter u_output (
      .clk(clk), .rst(rst), .en(out_hs), .clr(go), .row_fast(1'b1),
      .n_rows(n2_q), .n_cols(n35_q), .row(out_row), .col(out_col), .last(out_last)
   );

   always_comb begin
      bus.wr_row = '0;
      bus.wr_col = '0;
      bus.rd_row = '0;
      bus.rd_col = '0;
      case (state)
         FILL: begin
            bus.wr_row = fill_row;
            bus.wr_col = fill_col;
         end
         XFER1: begin
            bus.wr_row = col_row;
            bus.wr_col = col_col;
            bus.rd_row = iss_row;
            bus.rd_col = iss_col;
         end
         XFER2: begin
            bus.rd_row = out_row;
            bus.rd_col = out_col;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending <= '0;
      end else if (go) begin
         pending <= '0;
      end else begin
         case ({issue_hs, res_acc})
            2'b10:   pending <= pending + 16'd1;
            2'b01:   pending <= pending - 16'd1;
            default: pending <= pending;
         endcase
      end
   end

   // Every handshake valid is a flop set/cleared alongside the state, so no ready
   // input reaches its valid output combinationally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         n2_q        <= '0;
         n35_q       <= '0;
         s_ready_q   <= 1'b0;
         eng_valid_q <= 1'b0;
         out_valid_q <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cfg_err     <= 1'b0;
         proto_err   <= 1'b0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         if (bus.res_valid && !res_acc && (state != IDLE)) begin
            proto_err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  n2_q      <= cfg_n2;
                  n35_q     <= cfg_n35;
                  proto_err <= 1'b0;
                  if (cfg_legal(cfg_n2, cfg_n35)) begin
                     state     <= FILL;
                     s_ready_q <= 1'b1;
                     busy      <= 1'b1;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            FILL: begin
               if (fill_hs && fill_last) begin
                  state       <= XFER1;
                  s_ready_q   <= 1'b0;
                  eng_valid_q <= 1'b1;
               end
            end
            XFER1: begin
               if (issue_hs && iss_last) begin
                  eng_valid_q <= 1'b0;
               end
               if (res_acc && col_last) begin
                  state       <= XFER2;
                  out_valid_q <= 1'b1;
               end
            end
            XFER2: begin
               if (out_hs && out_last) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_transpose_ctrl.sv
// Scoreboard bench for fft_transpose_ctrl: expected write/issue/output addresses are
// queued per transform and popped by a monitor on every strobe or handshake.
module tb_fft_transpose_ctrl;
   import fft_tr_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [8:0] cfg_n2;
   logic [7:0] cfg_n35;
   logic       busy, done, cfg_err, proto_err;

   fft_transpose_ctrl_if bus ();

   fft_transpose_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .cfg_n2(cfg_n2), .cfg_n35(cfg_n35),
      .bus(bus), .busy(busy), .done(done), .cfg_err(cfg_err), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   logic [15:0] exp_wr[$];
   logic [15:0] exp_iss[$];
   logic [15:0] exp_out[$];
   int          due_q[$];

   int n_cur = 0;
   int fill_left = 0;
   int eng_lat = 1;
   int cyc = 0;
   int bp_at = -1;
   int bp_hold = 0;
   bit bp_done = 1'b1;
   bit spur_req = 1'b0;
   bit spur = 1'b0;
   bit spur_pend = 1'b0;
   bit out_rand = 1'b0;
   int wr_cnt, iss_cnt, out_cnt, done_cnt, first_out_cyc, done_cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   task automatic fail_now(input string name, input int act, input int req);
      checks++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
   endtask

   // Environment driver (engine model, ready/valid sources) and monitor share one loop.
   initial begin
      bus.s_valid   = 1'b0;
      bus.eng_ready = 1'b1;
      bus.res_valid = 1'b0;
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         bus.res_valid = 1'b0;
         spur = 1'b0;
         if (due_q.size() > 0) begin
            if (due_q[0] <= cyc) begin
               bus.res_valid = 1'b1;
               void'(due_q.pop_front());
            end
         end
         if (bp_hold > 0) bp_hold--;
         else if (!bp_done && bus.eng_valid && iss_cnt == bp_at) begin
            bp_hold = 5;
            bp_done = 1'b1;
            if (spur_req) begin
               spur = 1'b1;
               spur_req = 1'b0;
            end
         end
         bus.eng_ready = (bp_hold == 0);
         bus.res_valid = bus.res_valid | spur;
         bus.s_valid   = (fill_left > 0);
         bus.out_ready = out_rand ? ($urandom_range(0, 1) == 1) : 1'b1;

         @(negedge clk);
         if (spur) begin
            check("spur_no_write", bus.wr_en, 0);
            spur_pend = 1'b1;
         end else if (spur_pend) begin
            check("proto_err_set", proto_err, 1);
            spur_pend = 1'b0;
         end
         if (bus.s_valid && bus.s_ready) fill_left--;
         if (bus.wr_en) begin
            if (exp_wr.size() == 0) fail_now("wr_unexpected", wr_cnt, n_cur * 2);
            else check("wr_addr", {bus.wr_row, bus.wr_col}, exp_wr.pop_front());
            wr_cnt++;
         end
         if (bus.eng_valid) begin
            if (exp_iss.size() == 0) fail_now("iss_unexpected", iss_cnt, n_cur);
            else if (bus.eng_ready) check("iss_addr", {bus.rd_row, bus.rd_col}, exp_iss.pop_front());
            else check("iss_hold", {bus.rd_row, bus.rd_col}, exp_iss[0]);
            if (bus.eng_ready) begin
               iss_cnt++;
               due_q.push_back(cyc + eng_lat);
            end
         end
         if (bp_hold > 0) check("eng_valid_held", bus.eng_valid, 1);
         if (bus.out_valid) begin
            if (first_out_cyc < 0) begin
               first_out_cyc = cyc;
               check("res_before_xfer2", wr_cnt, 2 * n_cur);
               check("busy_run", busy, 1);
            end
            if (bus.out_ready) begin
               if (exp_out.size() == 0) fail_now("out_unexpected", out_cnt, n_cur);
               else check("out_addr", {bus.rd_row, bus.rd_col}, exp_out.pop_front());
               out_cnt++;
            end else if (exp_out.size() > 0) begin
               check("out_hold", {bus.rd_row, bus.rd_col}, exp_out[0]);
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic push_expect(input int n2, input int n35);
      exp_wr.delete();
      exp_iss.delete();
      exp_out.delete();
      due_q.delete();
      n_cur = n2 * n35;
      for (int c = 0; c < n35; c++)
         for (int r = 0; r < n2; r++) exp_wr.push_back({8'(r), 8'(c)});
      for (int r = 0; r < n2; r++)
         for (int c = 0; c < n35; c++) begin
            exp_wr.push_back({8'(r), 8'(c)});
            exp_iss.push_back({8'(r), 8'(c)});
         end
      for (int c = 0; c < n35; c++)
         for (int r = 0; r < n2; r++) exp_out.push_back({8'(r), 8'(c)});
      wr_cnt = 0; iss_cnt = 0; out_cnt = 0; done_cnt = 0;
      first_out_cyc = -1; done_cyc = -1;
   endtask

   task automatic pulse_start(input logic [8:0] n2, input logic [7:0] n35);
      @(posedge clk);
      #2;
      start = 1'b1;
      cfg_n2 = n2;
      cfg_n35 = n35;
      @(posedge clk);
      #2;
      start = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_strobes"}, {busy, bus.s_ready, bus.eng_valid, bus.out_valid, bus.wr_en,
                                done, cfg_err, proto_err}, 0);
      check({tag, "_addr"}, {bus.wr_row, bus.wr_col, bus.rd_row, bus.rd_col}, 0);
   endtask

   task automatic cfg_err_case(input logic [8:0] n2, input logic [7:0] n35);
      pulse_start(n2, n35);
      @(negedge clk);
      check("cfg_err_pulse", cfg_err, 1);
      check("cfg_err_busy", busy, 0);
      @(negedge clk);
      check("cfg_err_clear", cfg_err, 0);
      check("cfg_err_idle", busy, 0);
   endtask

   task automatic reset_mid_xfer1();
      int w = 0;
      push_expect(4, 3);
      eng_lat = 1; bp_done = 1'b1; out_rand = 1'b0;
      fill_left = n_cur;
      pulse_start(9'd4, 8'd3);
      while (iss_cnt < 3 && w < 200) begin
         @(negedge clk);
         #1;
         w++;
      end
      if (iss_cnt < 3) fail_now("xfer1_timeout", iss_cnt, 3);
      @(posedge clk);
      #3;
      rst = 1'b0;
      exp_wr.delete(); exp_iss.delete(); exp_out.delete(); due_q.delete();
      fill_left = 0;
      @(negedge clk);
      check_reset("mid_xfer1");
      #3;
      rst = 1'b1;
   endtask

   task automatic check_output(input bit rnd, input bit exp_proto);
      check("done_pulses", done_cnt, 1);
      check("busy_idle", busy, 0);
      check("out_count", out_cnt, n_cur);
      check("wr_count", wr_cnt, 2 * n_cur);
      check("queues_drained", exp_wr.size() + exp_iss.size() + exp_out.size(), 0);
      check("proto_err", proto_err, exp_proto);
      if (!rnd) check("done_latency", done_cyc - first_out_cyc, n_cur);
   endtask

   task automatic apply_stimulus(input int n2, input int n35, input int lat, input int bpat,
                                 input bit spur_on, input bit rnd, input bit exp_proto);
      int budget;
      int w = 0;
      push_expect(n2, n35);
      eng_lat = lat;
      bp_at = bpat;
      bp_done = (bpat < 0);
      bp_hold = 0;
      spur_req = spur_on;
      out_rand = rnd;
      fill_left = n_cur;
      pulse_start(9'(n2), 8'(n35));
      budget = 6 * n_cur + 200;
      while (done_cnt == 0 && w < budget) begin
         @(negedge clk);
         #1;
         w++;
      end
      if (done_cnt == 0) fail_now("done_timeout", w, budget);
      repeat (3) @(negedge clk);
      #1;
      check_output(rnd, exp_proto);
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      cfg_n2 = '0;
      cfg_n35 = '0;
      repeat (2) @(negedge clk);
      check_reset("por");
      #3;
      rst = 1'b1;

      cfg_err_case(9'd0, 8'd3);
      cfg_err_case(9'd4, 8'd244);
      cfg_err_case(9'd257, 8'd3);
      cfg_err_case(9'd4, 8'd0);

      reset_mid_xfer1();

      apply_stimulus(4, 3, 1, -1, 1'b0, 1'b0, 1'b0);
      apply_stimulus(4, 3, 1, 4, 1'b0, 1'b0, 1'b0);
      apply_stimulus(4, 3, 7, 0, 1'b1, 1'b0, 1'b1);
      apply_stimulus(4, 3, 3, -1, 1'b0, 1'b1, 1'b0);
      apply_stimulus(256, 3, 2, 100, 1'b0, 1'b1, 1'b0);
      apply_stimulus(2, 243, 1, -1, 1'b0, 1'b1, 1'b0);
      apply_stimulus(1, 1, 1, -1, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1, 5, 4, -1, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
